// File: rtl/pdpm_axis_pkt_buf.sv
// -----------------------------------------------------------------------------
// pdpm_axis_pkt_buf
//
// Store-and-forward AXI-Stream packet buffer. Frames are written into a RAM
// behind a speculative write pointer. A frame becomes visible to the read side
// only once its tlast beat is stored with tuser clear. Bad frames (tuser set on
// tlast) and frames that do not fit are rewound and counted.
//
// Parameters:
//   DATA_W        stream data width
//   ADDR_W        log2 of buffer depth in beats
//   DROP_ON_FULL  1: never backpressure, drop the frame on overflow
//                 0: backpressure while full; oversize frames are still dropped
//   CNT_W         width of the saturating drop counters
//
// Ports:
//   sys_clk, glbl_rst           single clock, synchronous active-high reset
//   s_axis_*                    receive stream from the MAC (tuser = bad frame)
//   m_axis_*                    transmit stream to the memory subsystem
//   fifo_level                  beats held, including an uncommitted frame
//   pkt_cnt                     committed frames not yet fully read out
//   drop_ovf_cnt, drop_err_cnt  saturating drop counters
// -----------------------------------------------------------------------------
module pdpm_axis_pkt_buf #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 11,
  parameter int DROP_ON_FULL = 1,
  parameter int CNT_W        = 16
) (
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   fifo_level,
  output logic [ADDR_W:0]   pkt_cnt,
  output logic [CNT_W-1:0]  drop_ovf_cnt,
  output logic [CNT_W-1:0]  drop_err_cnt
);

  localparam int DEPTH = 32'sd1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  logic [DATA_W:0] mem [DEPTH];

  state_t          state;
  logic            run;
  logic [ADDR_W:0] wr_cur;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] rd_addr;

  logic            full;
  logic            stall;
  logic            accept;
  logic            do_store;
  logic            do_commit;
  logic            do_rewind;
  logic            err_drop;
  logic            ovf_drop;

  logic            s1_valid;
  logic [DATA_W:0] s1_q;
  logic            s1_move;
  logic            rd_en;
  logic            out_hs;
  logic            last_out;

  // rd_ptr only advances on an output handshake, so beats sitting in the
  // prefetch stages still count as occupied and cannot be overwritten.
  assign full   = (wr_cur - rd_ptr) == DEPTH_V;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign s_axis_tready = run && !stall;

  assign out_hs   = m_axis_tvalid && m_axis_tready;
  assign last_out = out_hs && m_axis_tlast;
  assign s1_move  = s1_valid && (!m_axis_tvalid || m_axis_tready);
  // Prefetch only committed data, and only when stage 1 will have room.
  assign rd_en    = (rd_addr != wr_ptr) && (pkt_cnt != '0) && (!s1_valid || s1_move);

  // Backpressure only when committed frames exist to drain; a full buffer
  // holding nothing committed means the frame is oversize and must be dropped.
  always_comb begin
    stall = 1'b0;
    if ((DROP_ON_FULL == 32'sd0) && (state != ST_DROP) && full && (pkt_cnt != '0)) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Input beat decode: what the accepted beat does to the write side.
  always_comb begin
    do_store  = 1'b0;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    err_drop  = 1'b0;
    ovf_drop  = 1'b0;
    case (state)
      ST_IDLE, ST_WRITE: begin
        if (accept) begin
          if (s_axis_tlast && s_axis_tuser) begin
            do_rewind = 1'b1;
            err_drop  = 1'b1;
          end else if (full) begin
            do_rewind = 1'b1;
            ovf_drop  = s_axis_tlast;
          end else begin
            do_store  = 1'b1;
            do_commit = s_axis_tlast;
          end
        end else begin
          do_store = 1'b0;
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          ovf_drop = 1'b1;
        end else begin
          ovf_drop = 1'b0;
        end
      end
      default: begin
        do_store = 1'b0;
      end
    endcase
  end

  // Input state machine, write pointers, occupancy and statistics.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state        <= ST_IDLE;
      run          <= 1'b0;
      wr_cur       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      pkt_cnt      <= '0;
      drop_ovf_cnt <= '0;
      drop_err_cnt <= '0;
    end else begin
      run <= 1'b1;

      case (state)
        ST_IDLE, ST_WRITE: begin
          if (accept) begin
            // tlast always ends the frame; a rewound non-last beat starts a drop.
            state <= s_axis_tlast ? ST_IDLE : (do_store ? ST_WRITE : ST_DROP);
          end
        end
        ST_DROP: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_rewind) begin
        wr_cur <= wr_ptr;
      end else if (do_store) begin
        wr_cur <= wr_cur + PTR_ONE;
      end

      if (do_commit) begin
        wr_ptr <= wr_cur + PTR_ONE;
      end

      rd_ptr <= rd_ptr + {{ADDR_W{1'b0}}, out_hs};

      // Kept equal to wr_cur - rd_ptr of the following cycle.
      if (do_rewind) begin
        fifo_level <= wr_ptr - rd_ptr - {{ADDR_W{1'b0}}, out_hs};
      end else begin
        fifo_level <= fifo_level + {{ADDR_W{1'b0}}, do_store} - {{ADDR_W{1'b0}}, out_hs};
      end

      case ({do_commit, last_out})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase

      if (ovf_drop) begin
        drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
      end
      if (err_drop) begin
        drop_err_cnt <= sat_inc(drop_err_cnt);
      end
    end
  end

  // Buffer RAM: write port on stored beats, registered read port for prefetch.
  always_ff @(posedge sys_clk) begin
    if (do_store) begin
      mem[wr_cur[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
    if (rd_en) begin
      s1_q <= mem[rd_addr[ADDR_W-1:0]];
    end
  end

  // Two-stage read pipeline: RAM output (stage 1) feeding the output register.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      rd_addr       <= '0;
      s1_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (rd_en) begin
        rd_addr  <= rd_addr + PTR_ONE;
        s1_valid <= 1'b1;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      if (s1_move) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s1_q[DATA_W];
        m_axis_tdata  <= s1_q[DATA_W-1:0];
      end else if (out_hs) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdpm_axis_pkt_buf.sv
// -----------------------------------------------------------------------------
// Bench for pdpm_axis_pkt_buf. Two instances with ADDR_W=4, DATA_W=8, CNT_W=3:
// index 0 backpressures when full, index 1 drops on full. Output beats are
// checked against per-instance scoreboard queues filled as stimulus is driven.
// -----------------------------------------------------------------------------
module tb_pdpm_axis_pkt_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data  [2];
  logic       s_valid [2];
  logic       s_last  [2];
  logic       s_user  [2];
  logic       s_ready [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic       m_last  [2];
  logic       m_rdy   [2];
  logic [4:0] lvl     [2];
  logic [4:0] pcnt    [2];
  logic [2:0] ovf     [2];
  logic [2:0] err     [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];

  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    bit         bad;
    int         exp_err;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  pdpm_axis_pkt_buf #(.DATA_W(8), .ADDR_W(4), .DROP_ON_FULL(0), .CNT_W(3)) dut0 (
    .sys_clk(clk), .glbl_rst(rst),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tlast(s_last[0]),
    .s_axis_tuser(s_user[0]), .s_axis_tready(s_ready[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tlast(m_last[0]),
    .m_axis_tready(m_rdy[0]),
    .fifo_level(lvl[0]), .pkt_cnt(pcnt[0]), .drop_ovf_cnt(ovf[0]), .drop_err_cnt(err[0])
  );

  pdpm_axis_pkt_buf #(.DATA_W(8), .ADDR_W(4), .DROP_ON_FULL(1), .CNT_W(3)) dut1 (
    .sys_clk(clk), .glbl_rst(rst),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tlast(s_last[1]),
    .s_axis_tuser(s_user[1]), .s_axis_tready(s_ready[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tlast(m_last[1]),
    .m_axis_tready(m_rdy[1]),
    .fifo_level(lvl[1]), .pkt_cnt(pcnt[1]), .drop_ovf_cnt(ovf[1]), .drop_err_cnt(err[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    if (i == 0) return exp_q0.size();
    else return exp_q1.size();
  endfunction

  task automatic push(input int i, input logic [8:0] v);
    if (i == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  // Output monitor: scoreboard pop on handshake, stability under stall, pkt_cnt range.
  task automatic monitor();
    bit         pv [2];
    bit         pr [2];
    logic [8:0] pd [2];
    logic [8:0] e;
    int         n;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst || !mon_en) begin
          pv[i] = 1'b0;
          pr[i] = 1'b0;
        end else begin
          if (pv[i] && !pr[i]) begin
            chk($sformatf("stall_valid[%0d]", i), m_valid[i], 1);
            chk($sformatf("stall_data[%0d]", i), {m_last[i], m_data[i]}, pd[i]);
          end
          chk($sformatf("pkt_cnt_range[%0d]", i), (pcnt[i] <= 5'd16), 1);
          if (m_valid[i] && m_rdy[i]) begin
            n = qsize(i);
            chk($sformatf("expected_beat_pending[%0d]", i), (n > 0), 1);
            if (n > 0) begin
              if (i == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              chk($sformatf("out_beat[%0d]", i), {m_last[i], m_data[i]}, e);
            end
          end
          pv[i] = m_valid[i];
          pr[i] = m_rdy[i];
          pd[i] = {m_last[i], m_data[i]};
        end
      end
    end
  endtask

  // Drive one beat and hold it until accepted (bounded); optionally randomise m_rdy.
  task automatic send_beat(input int i, input logic [7:0] d, input bit last, input bit user,
                           input bit rnd);
    bit ok;
    ok = 1'b0;
    s_data[i] = d; s_last[i] = last; s_user[i] = user; s_valid[i] = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready[i];
      @(posedge clk);
      #1;
      if (rnd) m_rdy[i] = ($urandom_range(0, 1) == 1);
    end
    s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = 1'b0;
    chk($sformatf("beat_accepted[%0d]", i), ok, 1);
  endtask

  task automatic send_frame(input int i, input int len, input logic [7:0] base,
                            input logic [7:0] step, input bit bad, input bit exp_out,
                            input bit rnd);
    logic [7:0] d;
    bit         last;
    for (int k = 0; k < len; k++) begin
      d = base + 8'(k) * step;
      last = (k == len - 1);
      if (exp_out) push(i, {last, d});
      send_beat(i, d, last, bad && last, rnd);
    end
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk);
      #1;
      done = (pcnt[i] == 5'd0) && (lvl[i] == 5'd0) && !m_valid[i] && (qsize(i) == 0);
    end
    chk($sformatf("drained[%0d]", i), done, 1);
  endtask

  task automatic check_zero(input int i, input string tag);
    chk($sformatf("%s_s_ready[%0d]", tag, i), s_ready[i], 0);
    chk($sformatf("%s_m_valid[%0d]", tag, i), m_valid[i], 0);
    chk($sformatf("%s_m_last[%0d]", tag, i), m_last[i], 0);
    chk($sformatf("%s_m_data[%0d]", tag, i), m_data[i], 0);
    chk($sformatf("%s_fifo_level[%0d]", tag, i), lvl[i], 0);
    chk($sformatf("%s_pkt_cnt[%0d]", tag, i), pcnt[i], 0);
    chk($sformatf("%s_drop_ovf[%0d]", tag, i), ovf[i], 0);
    chk($sformatf("%s_drop_err[%0d]", tag, i), err[i], 0);
  endtask

  initial begin
    vecs[0] = '{3, 8'h10, 8'h01, 1'b1, 1};
    vecs[1] = '{2, 8'hAA, 8'h11, 1'b0, 1};
    vecs[2] = '{1, 8'h20, 8'h01, 1'b0, 1};
    vecs[3] = '{16, 8'h30, 8'h01, 1'b0, 1};
    vecs[4] = '{1, 8'h50, 8'h01, 1'b1, 2};
    vecs[5] = '{4, 8'h60, 8'h01, 1'b0, 2};
    vecs[6] = '{5, 8'h70, 8'h01, 1'b1, 3};

    for (int i = 0; i < 2; i++) begin
      s_data[i] = 8'h00; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = 1'b0;
      m_rdy[i] = 1'b0;
    end
    rst = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_zero(i, "reset");
    rst = 1'b0;
    m_rdy[0] = 1'b1;
    m_rdy[1] = 1'b1;
    mon_en = 1'b1;

    // Basic transfer with exact latency and no bubbles.
    send_frame(1, 5, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("basic_pkt_cnt_commit", pcnt[1], 1);
    chk("basic_valid_lat0", m_valid[1], 0);
    @(posedge clk); #1;
    chk("basic_valid_lat1", m_valid[1], 0);
    @(posedge clk); #1;
    chk("basic_valid_lat2", m_valid[1], 1);
    chk("basic_first_data", m_data[1], 8'h01);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("basic_no_bubble", m_valid[1], 1);
    end
    @(posedge clk); #1;
    chk("basic_valid_end", m_valid[1], 0);
    chk("basic_pkt_cnt_end", pcnt[1], 0);
    chk("basic_level_end", lvl[1], 0);

    // Table-driven good/bad frames on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 7; v++) begin
        send_frame(i, vecs[v].len, vecs[v].base, vecs[v].step, vecs[v].bad, !vecs[v].bad, 1'b0);
        chk($sformatf("vec%0d_drop_err[%0d]", v, i), err[i], vecs[v].exp_err);
        wait_idle(i);
        chk($sformatf("vec%0d_level[%0d]", v, i), lvl[i], 0);
        chk($sformatf("vec%0d_drop_ovf[%0d]", v, i), ovf[i], 0);
      end
    end

    // Overflow drop on the drop-on-full instance.
    m_rdy[1] = 1'b0;
    send_frame(1, 10, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("ovf_first_committed", pcnt[1], 1);
    for (int k = 0; k < 10; k++) begin
      chk("ovf_s_ready", s_ready[1], 1);
      send_beat(1, 8'h90 + 8'(k), (k == 9), 1'b0, 1'b0);
      if (k == 5) chk("ovf_level_full", lvl[1], 16);
      if (k == 6) chk("ovf_level_rewound", lvl[1], 10);
    end
    chk("ovf_drop_cnt", ovf[1], 1);
    chk("ovf_pkt_cnt", pcnt[1], 1);
    chk("ovf_drop_err_kept", err[1], 3);
    m_rdy[1] = 1'b1;
    wait_idle(1);

    // Backpressure on the stalling instance.
    m_rdy[0] = 1'b0;
    send_frame(0, 10, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) push(0, {(k == 9), 8'h90 + 8'(k)});
    for (int k = 0; k < 6; k++) send_beat(0, 8'h90 + 8'(k), 1'b0, 1'b0, 1'b0);
    chk("bp_level_full", lvl[0], 16);
    chk("bp_s_ready_low", s_ready[0], 0);
    s_data[0] = 8'h96; s_last[0] = 1'b0; s_user[0] = 1'b0; s_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stalled_ready", s_ready[0], 0);
    chk("bp_stalled_level", lvl[0], 16);
    m_rdy[0] = 1'b1;
    for (int k = 6; k < 10; k++) send_beat(0, 8'h90 + 8'(k), (k == 9), 1'b0, 1'b0);
    wait_idle(0);
    chk("bp_drop_ovf", ovf[0], 0);
    // Oversize frame on an empty buffer must be dropped rather than deadlock.
    for (int k = 0; k < 20; k++) begin
      send_beat(0, 8'hC0 + 8'(k), (k == 19), 1'b0, 1'b0);
      if (k == 15) begin
        chk("big_level_full", lvl[0], 16);
        chk("big_s_ready", s_ready[0], 1);
      end
    end
    chk("big_drop_ovf", ovf[0], 1);
    wait_idle(0);

    // Random output stall with one-beat frames every cycle.
    for (int k = 0; k < 60; k++) send_frame(0, 1, 8'(k), 8'h01, 1'b0, 1'b1, 1'b1);
    m_rdy[0] = 1'b1;
    wait_idle(0);

    // Reset mid-frame with buffered frames and one instance in DROP.
    m_rdy[0] = 1'b0;
    m_rdy[1] = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(0, 8'hE0 + 8'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) send_beat(0, 8'hE8 + 8'(k), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++) send_beat(1, 8'hD0 + 8'(k), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_pkt_cnt", pcnt[0], 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_zero(i, "midreset");
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_rdy[0] = 1'b1;
    m_rdy[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_frame(i, 2, 8'hF1, 8'h01, 1'b0, 1'b1, 1'b0);
      wait_idle(i);
      chk($sformatf("post_reset_ovf[%0d]", i), ovf[i], 0);
    end

    // Saturating error counter (CNT_W=3).
    for (int k = 0; k < 9; k++) send_frame(1, 1, 8'h33, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("err_saturated", err[1], 7);
    wait_idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
